// File: rtl/spi_shift_engine_pkg.sv
// spi_defines: shared sizes, state encoding and counter type for the SPI shift engine
package spi_defines;
  localparam int SPI_MAX_CHAR = 32;
  localparam int SPI_CHAR_LEN_BITS = 5;
  localparam int CNT_W = SPI_CHAR_LEN_BITS + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: control, strobe and data signals between the clock generator side and the shift engine
interface spi_shift_engine_if;
  import spi_defines::*;
  logic go;
  logic [SPI_CHAR_LEN_BITS-1:0] len;
  logic lsb;
  logic tx_negedge;
  logic rx_negedge;
  logic pos_edge;
  logic neg_edge;
  logic [SPI_MAX_CHAR-1:0] tx_data;
  logic miso;
  logic mosi;
  logic tip;
  logic last_bit;
  logic [SPI_MAX_CHAR-1:0] rx_data;
  logic done;
  modport master (
    output go, len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, tx_data, miso,
    input  mosi, tip, last_bit, rx_data, done
  );
  modport slave (
    input  go, len, lsb, tx_negedge, rx_negedge, pos_edge, neg_edge, tx_data, miso,
    output mosi, tip, last_bit, rx_data, done
  );
endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: moves one 1..SPI_MAX_CHAR bit character per go, driving mosi and sampling miso on generator strobes
module spi_shift_engine
  import spi_defines::*;
(
  input  logic clk_in,
  input  logic rst_n,
  spi_shift_engine_if.slave bus
);
  logic [0:0] state;
  logic [SPI_MAX_CHAR-1:0] tx_sr;
  logic [SPI_MAX_CHAR-1:0] rx_data;
  cnt_t tx_cnt;
  cnt_t rx_cnt;
  cnt_t len_l;
  cnt_t l_eff;
  logic lsb_l;
  logic mosi;
  logic done;
  logic tx_edge;
  logic rx_edge;
  // c counts remaining bits, so LSB-first walks upward from 0 and MSB-first downward from L-1
  function automatic logic [SPI_CHAR_LEN_BITS-1:0] bit_idx(input logic lsb_first, input cnt_t l, input cnt_t c);
    return lsb_first ? SPI_CHAR_LEN_BITS'(l - c) : SPI_CHAR_LEN_BITS'(c - cnt_t'(1));
  endfunction
  always_comb begin
    l_eff = bus.len == '0 ? cnt_t'(SPI_MAX_CHAR) : {1'b0, bus.len};
    tx_edge = bus.tx_negedge ? bus.neg_edge : bus.pos_edge;
    rx_edge = bus.rx_negedge ? bus.neg_edge : bus.pos_edge;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state <= IDLE;
      tx_sr <= '0;
      rx_data <= '0;
      tx_cnt <= '0;
      rx_cnt <= '0;
      len_l <= '0;
      lsb_l <= 1'b0;
      mosi <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.go) begin
          tx_sr <= bus.tx_data;
          rx_data <= '0;
          tx_cnt <= l_eff - cnt_t'(1);
          rx_cnt <= l_eff;
          len_l <= l_eff;
          lsb_l <= bus.lsb;
          mosi <= bus.tx_data[bit_idx(bus.lsb, l_eff, l_eff)];
          state <= SHIFT;
        end
      end else begin
        if (tx_edge && tx_cnt != '0) begin
          mosi <= tx_sr[bit_idx(lsb_l, len_l, tx_cnt)];
          tx_cnt <= tx_cnt - cnt_t'(1);
        end
        if (rx_edge) begin
          rx_data[bit_idx(lsb_l, len_l, rx_cnt)] <= bus.miso;
          rx_cnt <= rx_cnt - cnt_t'(1);
          if (rx_cnt == cnt_t'(1)) begin
            done <= 1'b1;
            state <= IDLE;
          end
        end
      end
    end
  end
  assign bus.mosi = mosi;
  assign bus.tip = state == SHIFT;
  assign bus.last_bit = state == SHIFT && rx_cnt == cnt_t'(1);
  assign bus.rx_data = rx_data;
  assign bus.done = done;
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed transfers checked every cycle against a bit-order model of the shift engine
module tb_spi_shift_engine;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic loop = 1'b1;
  logic miso_drv = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int lb = 0;
  bit chk_on = 1'b0;
  logic [31:0] cap = '0;
  always #5 clk_in = ~clk_in;
  spi_shift_engine_if bus();
  assign bus.miso = loop ? bus.mosi : miso_drv;
  spi_shift_engine dut (.clk_in(clk_in), .rst_n(rst_n), .bus(bus));
  bit m_busy = 1'b0;
  bit m_lsb = 1'b0;
  bit m_done = 1'b0;
  logic m_mosi = 1'b0;
  int m_L = 1;
  int m_txk = 0;
  int m_rxk = 0;
  logic [31:0] m_word = '0;
  logic [31:0] m_rx = '0;
  function automatic int pos_of(int k);
    return m_lsb ? k : m_L - 1 - k;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: k-th transmitted bit (0-based) lives at pos_of(k); miso seen at a sample is the pre-edge line value
  initial forever begin
    logic ms;
    logic txe;
    logic rxe;
    @(posedge clk_in);
    ms = loop ? m_mosi : miso_drv;
    txe = bus.tx_negedge ? bus.neg_edge : bus.pos_edge;
    rxe = bus.rx_negedge ? bus.neg_edge : bus.pos_edge;
    if (!rst_n) begin
      m_busy = 0;
      m_done = 0;
      m_mosi = 0;
      m_rx = '0;
      m_txk = 0;
      m_rxk = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (bus.go) begin
          m_word = bus.tx_data;
          m_L = bus.len == 0 ? 32 : int'(bus.len);
          m_lsb = bus.lsb;
          m_rx = '0;
          m_txk = 1;
          m_rxk = 0;
          m_busy = 1;
          m_mosi = m_word[pos_of(0)];
        end
      end else begin
        if (rxe) begin
          m_rx[pos_of(m_rxk)] = ms;
          m_rxk++;
          if (m_rxk == m_L) begin
            m_busy = 0;
            m_done = 1;
          end
        end
        if (txe && m_txk < m_L) begin
          m_mosi = m_word[pos_of(m_txk)];
          m_txk++;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk_in);
    if (chk_on) begin
      chk("tip", bus.tip, m_busy);
      chk("mosi", bus.mosi, m_mosi);
      chk("done", bus.done, m_done);
      chk("last_bit", bus.last_bit, m_busy && (m_L - m_rxk == 1));
      chk("rx_data", bus.rx_data, m_rx);
      if (bus.done) n_done++;
    end
  end
  task automatic start(input logic [4:0] l, input bit lsb_first, input bit tn, input bit rn, input logic [31:0] d);
    bus.len = l;
    bus.lsb = lsb_first;
    bus.tx_negedge = tn;
    bus.rx_negedge = rn;
    bus.tx_data = d;
    bus.go = 1;
    @(negedge clk_in);
    bus.go = 0;
    cap = '0;
    lb = 0;
    n_done = 0;
    chk("go_tip", bus.tip, 1);
  endtask
  task automatic clock_run(input logic [31:0] mpat, input int gap);
    int j;
    int n;
    j = 0;
    n = 0;
    while (bus.tip && n < 200) begin
      for (int ph = 0; ph < 2; ph++) begin
        if (bus.tip && (ph == 1) == bus.rx_negedge && j < 32) begin
          miso_drv = mpat[j];
          cap = {cap[30:0], bus.mosi};
          if (bus.last_bit) lb++;
          j++;
        end
        bus.pos_edge = ph == 0;
        bus.neg_edge = ph == 1;
        @(negedge clk_in);
        bus.pos_edge = 0;
        bus.neg_edge = 0;
        repeat (gap) @(negedge clk_in);
      end
      n++;
    end
    chk("run_timeout_tip", bus.tip, 0);
  endtask
  initial begin
    int k;
    bus.go = 0;
    bus.len = '0;
    bus.lsb = 0;
    bus.tx_negedge = 1;
    bus.rx_negedge = 0;
    bus.pos_edge = 0;
    bus.neg_edge = 0;
    bus.tx_data = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_tip", bus.tip, 0);
    chk("rst_mosi", bus.mosi, 0);
    chk("rst_rx", bus.rx_data, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_last", bus.last_bit, 0);
    rst_n = 1;
    chk_on = 1;
    @(negedge clk_in);
    // MSB first, mode 0, loopback
    start(5'd8, 0, 1, 0, 32'h0000_00A5);
    clock_run('0, 1);
    repeat (2) @(negedge clk_in);
    chk("t1_mosi_seq", cap, 32'hA5);
    chk("t1_rx", bus.rx_data, 32'h0000_00A5);
    chk("t1_done_cnt", n_done, 1);
    // LSB first
    start(5'd8, 1, 1, 0, 32'h0000_00A5);
    clock_run('0, 0);
    repeat (2) @(negedge clk_in);
    chk("t2_mosi_seq", cap, 32'hA5);
    chk("t2_rx", bus.rx_data, 32'h0000_00A5);
    chk("t2_done_cnt", n_done, 1);
    // full 32-bit character
    start(5'd0, 0, 1, 0, 32'hDEAD_BEEF);
    clock_run('0, 1);
    repeat (2) @(negedge clk_in);
    chk("t3_mosi_seq", cap, 32'hDEAD_BEEF);
    chk("t3_rx", bus.rx_data, 32'hDEAD_BEEF);
    chk("t3_last_bit_edges", lb, 1);
    chk("t3_done_cnt", n_done, 1);
    // go mid-transfer and on the final rx edge are both ignored
    start(5'd8, 0, 1, 0, 32'h0000_003C);
    bus.tx_data = 32'hFF;
    for (int i = 0; i < 8; i++) begin
      cap = {cap[30:0], bus.mosi};
      bus.pos_edge = 1;
      bus.go = i == 7;
      @(negedge clk_in);
      bus.pos_edge = 0;
      bus.go = 0;
      if (i == 7) break;
      bus.go = i == 3;
      @(negedge clk_in);
      bus.go = 0;
      bus.neg_edge = 1;
      @(negedge clk_in);
      bus.neg_edge = 0;
      @(negedge clk_in);
    end
    chk("t4_rx", bus.rx_data, 32'h3C);
    chk("t4_mosi_seq", cap, 32'h3C);
    chk("t4_done", bus.done, 1);
    bus.tx_data = 32'h5A;
    bus.go = 1;
    @(negedge clk_in);
    bus.go = 0;
    chk("t4_next_go_tip", bus.tip, 1);
    chk("t4_done_cnt", n_done, 1);
    clock_run('0, 1);
    repeat (2) @(negedge clk_in);
    chk("t4_rx2", bus.rx_data, 32'h5A);
    // reset after 3 of 8 bits
    start(5'd8, 0, 1, 0, 32'h0000_00A5);
    repeat (3) begin
      bus.pos_edge = 1;
      @(negedge clk_in);
      bus.pos_edge = 0;
      bus.neg_edge = 1;
      @(negedge clk_in);
      bus.neg_edge = 0;
    end
    chk("t5_partial_rx", bus.rx_data, 32'hA0);
    rst_n = 0;
    @(negedge clk_in);
    rst_n = 1;
    chk("t5_tip", bus.tip, 0);
    chk("t5_rx", bus.rx_data, 0);
    chk("t5_mosi", bus.mosi, 0);
    repeat (4) begin
      bus.pos_edge = 1;
      bus.neg_edge = 1;
      @(negedge clk_in);
    end
    bus.pos_edge = 0;
    bus.neg_edge = 0;
    @(negedge clk_in);
    chk("t5_idle_tip", bus.tip, 0);
    chk("t5_idle_rx", bus.rx_data, 0);
    chk("t5_done_cnt", n_done, 0);
    // both strobes every cycle
    start(5'd4, 0, 1, 0, 32'h9);
    bus.pos_edge = 1;
    bus.neg_edge = 1;
    k = 0;
    while (k < 8) begin
      @(negedge clk_in);
      k++;
      if (bus.done) break;
    end
    bus.pos_edge = 0;
    bus.neg_edge = 0;
    chk("t6_done_latency", k, 4);
    chk("t6_rx", bus.rx_data, 32'h9);
    repeat (2) @(negedge clk_in);
    // external miso, LSB first, tx on pos / rx on neg
    loop = 0;
    start(5'd5, 1, 0, 1, 32'h16);
    clock_run(32'h0000_000B, 1);
    repeat (2) @(negedge clk_in);
    chk("t7_rx", bus.rx_data, 32'h0B);
    chk("t7_done_cnt", n_done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Bit-serial shift engine that sits directly downstream of the SPI clock generator. It consumes the generator's `pos_edge`/`neg_edge` strobes and drives MOSI. It samples MISO into a receive register. It feeds back `tip` (clock-generator enable) and `last_bit` (clock-generator last-clock flag) so that the generator stops after exactly one character. One character of 1..`SPI_MAX_CHAR` bits is moved per `go`, MSB- or LSB-first.

## Interface
- `SPI_MAX_CHAR`, 32: maximum character length in bits; also the width of the data registers.
- `SPI_CHAR_LEN_BITS`, 5: width of `len`; equals log2(`SPI_MAX_CHAR`).

Ports:
- `clk_in` in 1: system clock. Single clock domain.
- `rst_n` in 1: reset. Synchronous, active-low.
- `go` in 1: start pulse. Honoured only when idle.
- `len` in `SPI_CHAR_LEN_BITS`: character length. 0 encodes `SPI_MAX_CHAR`.
- `lsb` in 1: 1 = LSB first, 0 = MSB first.
- `tx_negedge` in 1: 1 = MOSI changes on `neg_edge`, 0 = on `pos_edge`.
- `rx_negedge` in 1: 1 = MISO sampled on `neg_edge`, 0 = on `pos_edge`.
- `pos_edge`, `neg_edge` in 1: one-cycle strobes from the clock generator.
- `tx_data` in `SPI_MAX_CHAR`: transmit word. Latched at accepted `go`.
- `miso` in 1: serial input. Already synchronised.
- `mosi` out 1: serial output.
- `tip` out 1: transfer in progress. Connects to the clock generator's enable.
- `last_bit` out 1: final bit pending. Connects to the clock generator's last-clock input.
- `rx_data` out `SPI_MAX_CHAR`: received word.
- `done` out 1: one-cycle pulse when the character completes.

## Operation
Effective length: `L` = (`len`==0) ? `SPI_MAX_CHAR` : `len`. `L` is computed at `go`; `len` and `lsb` are latched at `go`.

States:
- IDLE (`tip`=0). Transitions to SHIFT on `go`.
- SHIFT (`tip`=1). Transitions to IDLE when the final rx sample is taken.

Bit index for remaining-count `c`: `lsb` ? (`L`−`c`) : (`c`−1).

Accepted `go` (IDLE and `go`=1):
- `tx_sr` ← `tx_data`.
- `rx_data` ← 0.
- `tx_cnt` ← `L`−1.
- `rx_cnt` ← `L`.
- `mosi` ← `tx_sr` bit at index for `c`=`L`. This is the first bit, presented before any clock edge.
- `tip` ← 1.

Tx edge (`tx_negedge` ? `neg_edge` : `pos_edge`) in SHIFT with `tx_cnt`≠0:
- `mosi` ← bit at index for `c`=`tx_cnt`.
- `tx_cnt`−−.
- When `tx_cnt`=0, the tx edge is ignored and `mosi` holds.

Rx edge (`rx_negedge` ? `neg_edge` : `pos_edge`) in SHIFT:
- `rx_data`[index for `c`=`rx_cnt`] ← `miso`.
- `rx_cnt`−−.
- If `rx_cnt` was 1: `tip` ← 0, `done` ← 1 for one cycle, state goes to IDLE.

Other rules:
- `last_bit` = `tip` & (`rx_cnt`==1). This output is combinational from registers.
- Tx and rx edges in the same cycle are both processed; the tx and rx counters are independent.
- Edges arriving in IDLE are ignored.
- `go` in SHIFT is ignored; there is no queuing.
- `go` in the same cycle as the final rx edge is ignored; a new `go` is accepted from the next cycle.
- `mosi` holds its last value in IDLE.
- `rx_data` holds after `done` until the next accepted `go`. Bits at index ≥ `L` read 0.

## Timing
- Reset (`rst_n`=0 at a `clk_in` edge): `tip`=0, `done`=0, `mosi`=0, `rx_data`=0, counters=0, state IDLE. Reset mid-transfer aborts the transfer with no `done`.
- `go` → `tip`=1 and first `mosi` bit valid on the next cycle.
- Final rx edge at cycle N → `rx_data` complete, `tip`=0 and `done`=1 at N+1. `done` drops at N+2.
- `last_bit` rises the cycle after the second-to-last rx edge; this is in time for the generator to suppress its trailing toggle.
- All registers update on the rising edge of `clk_in`; there are no combinational paths from `miso` to outputs.

## Structure
- Shared package (`spi_defines`): `SPI_MAX_CHAR`, `SPI_CHAR_LEN_BITS`, and the state encoding (IDLE=0, SHIFT=1).
- No sub-module.
- Bit-index selection is a local function shared by the tx and rx paths.

## Test plan
- `len`=8, `lsb`=0, `tx_negedge`=1, `rx_negedge`=0, `tx_data`=0xA5, `miso` looped to `mosi` → `mosi` sequence 1,0,1,0,0,1,0,1; `rx_data`=0x000000A5; exactly one `done`.
- `len`=8, `lsb`=1, same data → `mosi` sequence 1,0,1,0,0,1,0,1 LSB-first (bit0..bit7); `rx_data`=0xA5.
- `len`=0, `tx_data`=0xDEADBEEF, loopback → 32 rx edges then `done`; `rx_data`=0xDEADBEEF; `last_bit` high only between the 31st and 32nd rx edge.
- `go` pulsed mid-transfer and coincident with the final rx edge → both ignored; `tx_sr` unchanged; one `done`; next `go` one cycle later accepted.
- `rst_n`=0 after 3 of 8 bits → next cycle `tip`=0, `rx_data`=0, `mosi`=0, no `done`; edges after reset ignored.
- `pos_edge` and `neg_edge` both asserted every cycle (divider 0), `len`=4, `tx_data`=0x9, loopback → `rx_data`=0x9; `done` four cycles after the first edge.
